// File: rtl/fft_pkg.sv
// Shared definitions for the FFT input framing path.
// Contents:
//   DATA_W, PTS_W, FFT_POINTS : default sample width, point-count width, frame length
//   CNT_W                     : frame index width for the default frame length
//   sample_t                  : signed sample type at the default width
//   is_pow2()                 : constant-foldable power-of-two test for parameter checks
package fft_pkg;

  localparam int DATA_W     = 14;
  localparam int PTS_W      = 11;
  localparam int FFT_POINTS = 1024;
  localparam int CNT_W      = $clog2(FFT_POINTS);

  typedef logic signed [DATA_W-1:0] sample_t;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/fft_frame_counter.sv
// Modulo-POINTS beat index counter for the FFT input framer.
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous active-high reset, returns the index to 0
//   advance  : step to the next index on this edge
//   is_first : current index is 0 (next loaded beat starts a frame)
//   is_last  : current index is POINTS-1 (next loaded beat ends a frame)
module fft_frame_counter #(
  parameter int POINTS = fft_pkg::FFT_POINTS,
  parameter int CNT_W  = fft_pkg::CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic advance,
  output logic is_first,
  output logic is_last
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(POINTS - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  // Explicit wrap keeps the frame length exact even if the width is ever
  // chosen larger than strictly needed.
  always_comb begin
    cnt_next = cnt_reg;
    if (advance) begin
      cnt_next = (cnt_reg == LAST_IDX) ? '0 : cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

  assign is_first = (cnt_reg == '0);
  assign is_last  = (cnt_reg == LAST_IDX);

endmodule

// File: rtl/fft_input_framer.sv
// Frames a continuous real sample stream into fixed-length Avalon-ST packets
// for the streaming FFT sink port.
// Ports:
//   clk, reset      : clock and asynchronous active-high reset
//   insignal        : one real sample per clock (offset-binary when OFFSET_BIN=1)
//   sink_ready      : FFT backpressure; a beat transfers when valid and ready
//   sink_valid/sop/eop, outreal : registered beat, two's complement data
//   sink_error, inverse, outimag, fft_pts : constant ties (no error, forward
//                     transform, zero imaginary part, frame length)
module fft_input_framer #(
  parameter int DATA_W     = fft_pkg::DATA_W,
  parameter int PTS_W      = fft_pkg::PTS_W,
  parameter int FFT_POINTS = fft_pkg::FFT_POINTS,
  parameter bit OFFSET_BIN = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] insignal,
  input  logic              sink_ready,
  output logic              sink_valid,
  output logic              sink_sop,
  output logic              sink_eop,
  output logic [1:0]        sink_error,
  output logic              inverse,
  output logic [DATA_W-1:0] outreal,
  output logic [DATA_W-1:0] outimag,
  output logic [PTS_W-1:0]  fft_pts
);

  import fft_pkg::*;

  localparam int FRAME_CNT_W = $clog2(FFT_POINTS);

  // Reject frame lengths the counter and the fft_pts port cannot represent.
  generate
    if (!is_pow2(FFT_POINTS) || (FFT_POINTS < 8) || (FFT_POINTS > 2 ** (PTS_W - 1))) begin : g_bad_points
      $error("fft_input_framer: FFT_POINTS must be a power of two in 8..2**(PTS_W-1)");
    end
  endgenerate

  logic [DATA_W-1:0] sample_conv;

  generate
    if (OFFSET_BIN) begin : g_offset_bin
      // Offset-binary to two's complement is a flip of the sign bit.
      assign sample_conv = {~insignal[DATA_W-1], insignal[DATA_W-2:0]};
    end else begin : g_twos_comp
      assign sample_conv = insignal;
    end
  endgenerate

  logic              valid_reg;
  logic              sop_reg;
  logic              eop_reg;
  logic [DATA_W-1:0] real_reg;
  logic              load;
  logic              is_first;
  logic              is_last;

  // A beat offered but not accepted must stay put; otherwise the register
  // refreshes every cycle. Samples arriving during a hold, or while ready is
  // low, are dropped by design (no buffering).
  assign load = !(valid_reg && !sink_ready);

  // The index only moves when the freshly loaded beat is actually offered,
  // so a stall pauses the frame rather than skipping positions.
  fft_frame_counter #(
    .POINTS (FFT_POINTS),
    .CNT_W  (FRAME_CNT_W)
  ) u_frame_counter (
    .clk      (clk),
    .reset    (reset),
    .advance  (load && sink_ready),
    .is_first (is_first),
    .is_last  (is_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= 1'b0;
      sop_reg   <= 1'b0;
      eop_reg   <= 1'b0;
      real_reg  <= '0;
    end else if (load) begin
      valid_reg <= sink_ready;
      sop_reg   <= is_first;
      eop_reg   <= is_last;
      real_reg  <= sample_conv;
    end
  end

  assign sink_valid = valid_reg;
  assign sink_sop   = sop_reg;
  assign sink_eop   = eop_reg;
  assign outreal    = real_reg;

  assign sink_error = 2'b00;
  assign inverse    = 1'b0;
  assign outimag    = '0;
  assign fft_pts    = PTS_W'(FFT_POINTS);

endmodule

// File: tb/tb_fft_input_framer.sv
module tb_fft_input_framer;

  import fft_pkg::*;

  localparam int N  = 1024;
  localparam int DW = 14;

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] insignal;
  logic          sink_ready;

  logic          sink_valid, sink_sop, sink_eop, inverse;
  logic [1:0]    sink_error;
  logic [DW-1:0] outreal, outimag;
  logic [10:0]   fft_pts;

  logic          o_valid, o_sop, o_eop, o_inverse;
  logic [1:0]    o_error;
  logic [DW-1:0] o_real, o_imag;
  logic [10:0]   o_pts;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fft_input_framer u_dut (
    .clk        (clk),
    .reset      (reset),
    .insignal   (insignal),
    .sink_ready (sink_ready),
    .sink_valid (sink_valid),
    .sink_sop   (sink_sop),
    .sink_eop   (sink_eop),
    .sink_error (sink_error),
    .inverse    (inverse),
    .outreal    (outreal),
    .outimag    (outimag),
    .fft_pts    (fft_pts)
  );

  fft_input_framer #(
    .FFT_POINTS (8),
    .OFFSET_BIN (1'b1)
  ) u_ofs (
    .clk        (clk),
    .reset      (reset),
    .insignal   (insignal),
    .sink_ready (sink_ready),
    .sink_valid (o_valid),
    .sink_sop   (o_sop),
    .sink_eop   (o_eop),
    .sink_error (o_error),
    .inverse    (o_inverse),
    .outreal    (o_real),
    .outimag    (o_imag),
    .fft_pts    (o_pts)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the active edge; outputs are read there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_consts();
    chk("fft_pts", 32'(fft_pts), 32'd1024);
    chk("sink_error", 32'(sink_error), 32'd0);
    chk("inverse", 32'(inverse), 32'd0);
    chk("outimag", 32'(outimag), 32'd0);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    sink_ready = 1'b0;
    insignal   = '0;
    step();
    step();
    chk("rst_valid", 32'(sink_valid), 32'd0);
    chk("rst_sop", 32'(sink_sop), 32'd0);
    chk("rst_eop", 32'(sink_eop), 32'd0);
    chk("rst_outreal", 32'(outreal), 32'd0);
    check_consts();
    reset = 1'b0;
  endtask

  // Transfer scoreboard, active only during the random-ready phase.
  bit mon_en = 1'b0;
  int mon_frames = 0;
  int mon_cnt = 0;

  always @(negedge clk) begin
    if (mon_en && sink_valid) begin
      chk("sop_eop_excl", 32'(sink_sop && sink_eop), 32'd0);
      if (sink_ready) begin
        if (sink_sop) begin
          if (mon_frames > 0) chk("frame_len", 32'(mon_cnt), 32'(N));
          mon_cnt = 0;
          mon_frames++;
        end
        if (mon_frames > 0) chk("eop_pos", 32'(sink_eop), 32'(mon_cnt == N - 1));
        mon_cnt++;
      end
    end
  end

  typedef struct {
    logic          rdy;
    logic [DW-1:0] din;
    logic          exp_valid;
    logic          exp_sop;
    logic          exp_eop;
    logic [DW-1:0] exp_real;
  } vec_t;

  vec_t tbl[11];
  sample_t held;

  initial begin
    reset      = 1'b1;
    sink_ready = 1'b0;
    insignal   = '0;

    // Startup and short stalls, hand-computed cycle by cycle.
    tbl[0]  = '{1'b0, 14'd7,  1'b0, 1'b1, 1'b0, 14'd7};
    tbl[1]  = '{1'b1, 14'd10, 1'b1, 1'b1, 1'b0, 14'd10};
    tbl[2]  = '{1'b1, 14'd11, 1'b1, 1'b0, 1'b0, 14'd11};
    tbl[3]  = '{1'b0, 14'd12, 1'b1, 1'b0, 1'b0, 14'd11};
    tbl[4]  = '{1'b0, 14'd13, 1'b1, 1'b0, 1'b0, 14'd11};
    tbl[5]  = '{1'b1, 14'd14, 1'b1, 1'b0, 1'b0, 14'd14};
    tbl[6]  = '{1'b0, 14'd15, 1'b1, 1'b0, 1'b0, 14'd14};
    tbl[7]  = '{1'b1, 14'd16, 1'b1, 1'b0, 1'b0, 14'd16};
    tbl[8]  = '{1'b1, 14'd17, 1'b1, 1'b0, 1'b0, 14'd17};
    tbl[9]  = '{1'b0, 14'd18, 1'b1, 1'b0, 1'b0, 14'd17};
    tbl[10] = '{1'b1, 14'd19, 1'b1, 1'b0, 1'b0, 14'd19};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      sink_ready = tbl[i].rdy;
      insignal   = tbl[i].din;
      step();
      chk($sformatf("tbl%0d_valid", i), 32'(sink_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_sop", i), 32'(sink_sop), 32'(tbl[i].exp_sop));
      chk($sformatf("tbl%0d_eop", i), 32'(sink_eop), 32'(tbl[i].exp_eop));
      chk($sformatf("tbl%0d_outreal", i), 32'(outreal), 32'(tbl[i].exp_real));
    end

    // Continuous ready with a ramp: two full frames plus a few beats.
    do_reset();
    chk("ramp_valid_before", 32'(sink_valid), 32'd0);
    for (int i = 0; i < 2 * N + 4; i++) begin
      sink_ready = 1'b1;
      insignal   = DW'(i);
      step();
      chk("ramp_outreal", 32'(outreal), 32'(i));
      chk("ramp_valid", 32'(sink_valid), 32'd1);
      chk("ramp_sop", 32'(sink_sop), 32'((i % N) == 0));
      chk("ramp_eop", 32'(sink_eop), 32'((i % N) == N - 1));
    end
    check_consts();

    // Five-cycle stall with beat 500 on the output.
    do_reset();
    for (int i = 0; i <= 500; i++) begin
      sink_ready = 1'b1;
      insignal   = DW'(i);
      step();
    end
    held = sample_t'(outreal);
    chk("stall_start_outreal", 32'(held), 32'd500);
    for (int s = 0; s < 5; s++) begin
      sink_ready = 1'b0;
      insignal   = 14'h3ABC;
      step();
      chk("stall_outreal", 32'(outreal), 32'd500);
      chk("stall_valid", 32'(sink_valid), 32'd1);
      chk("stall_sop", 32'(sink_sop), 32'd0);
      chk("stall_eop", 32'(sink_eop), 32'd0);
    end
    for (int k = 501; k <= N + 2; k++) begin
      sink_ready = 1'b1;
      insignal   = DW'(k + 1000);
      step();
      chk("resume_outreal", 32'(outreal), 32'(k + 1000));
      chk("resume_sop", 32'(sink_sop), 32'((k % N) == 0));
      chk("resume_eop", 32'(sink_eop), 32'((k % N) == N - 1));
    end

    // Asynchronous reset mid-frame at beat 300.
    do_reset();
    for (int i = 0; i <= 300; i++) begin
      sink_ready = 1'b1;
      insignal   = DW'(i + 5);
      step();
    end
    chk("pre_areset_valid", 32'(sink_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("areset_valid", 32'(sink_valid), 32'd0);
    chk("areset_sop", 32'(sink_sop), 32'd0);
    chk("areset_eop", 32'(sink_eop), 32'd0);
    chk("areset_outreal", 32'(outreal), 32'd0);
    check_consts();
    step();
    reset      = 1'b0;
    sink_ready = 1'b1;
    insignal   = 14'd77;
    step();
    chk("post_areset_valid", 32'(sink_valid), 32'd1);
    chk("post_areset_sop", 32'(sink_sop), 32'd1);
    chk("post_areset_outreal", 32'(outreal), 32'd77);

    // Offset-binary conversion on the second instance.
    insignal = 14'h2000;
    step();
    chk("ofs_2000", 32'(o_real), 32'h0000);
    chk("pass_2000", 32'(outreal), 32'h2000);
    insignal = 14'h0000;
    step();
    chk("ofs_0000", 32'(o_real), 32'h2000);
    chk("pass_0000", 32'(outreal), 32'h0000);
    chk("ofs_pts", 32'(o_pts), 32'd8);

    // Random backpressure over at least three complete frames.
    do_reset();
    mon_frames = 0;
    mon_cnt    = 0;
    mon_en     = 1'b1;
    for (int c = 0; c < 20000 && mon_frames < 4; c++) begin
      sink_ready = 1'($urandom_range(0, 1));
      insignal   = DW'($urandom);
      step();
    end
    mon_en = 1'b0;
    chk("random_frames_seen", 32'(mon_frames >= 4), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
